// File: rtl/bomba_alternador.sv
// rtl/bomba_alternador.sv - lead/lag duty controller for a two-pump tank
module bomba_alternador #(
    parameter int T_OFF   = 4,
    parameter int T_ASIST = 8,
    parameter int T_MAX   = 20,
    parameter int CW      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sensores_i,
    input  logic       ack_i,
    output logic [1:0] bomba_o,
    output logic       lider_o,
    output logic       alarma_o,
    output logic [1:0] falla_o
);

    typedef enum logic [2:0] {
        ESPERA,
        REPOSO,
        LLENANDO,
        ASISTENCIA,
        FALLA
    } state_t;

    localparam logic [CW-1:0] C_OFF   = CW'(T_OFF - 1);
    localparam logic [CW-1:0] C_ASIST = CW'(T_ASIST - 1);
    localparam logic [CW-1:0] C_MAX   = CW'(T_MAX - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    sync1;
    logic [2:0]    lvl;
    logic          lvl_ok;

    // Only thermometer codes are physically possible with stacked float sensors.
    assign lvl_ok = (lvl == 3'b000) || (lvl == 3'b001) ||
                    (lvl == 3'b011) || (lvl == 3'b111);

    // Outputs are loaded together with the next state so they stay pure
    // registered decodes of state and lead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 3'b000;
            lvl      <= 3'b000;
            state    <= ESPERA;
            cnt      <= '0;
            bomba_o  <= 2'b00;
            lider_o  <= 1'b0;
            alarma_o <= 1'b0;
            falla_o  <= 2'b00;
        end else begin
            sync1 <= sensores_i;
            lvl   <= sync1;
            case (state)
                ESPERA: begin
                    if (!lvl_ok) begin
                        state    <= FALLA;
                        falla_o  <= 2'b01;
                        alarma_o <= 1'b1;
                    end else if (cnt == C_OFF) begin
                        state <= REPOSO;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPOSO: begin
                    if (!lvl_ok) begin
                        state    <= FALLA;
                        falla_o  <= 2'b01;
                        alarma_o <= 1'b1;
                    end else if (lvl == 3'b000) begin
                        state   <= LLENANDO;
                        cnt     <= '0;
                        bomba_o <= lider_o ? 2'b10 : 2'b01;
                    end
                end
                LLENANDO, ASISTENCIA: begin
                    if (!lvl_ok) begin
                        state    <= FALLA;
                        falla_o  <= 2'b01;
                        alarma_o <= 1'b1;
                        bomba_o  <= 2'b00;
                    end else if (lvl == 3'b111) begin
                        state   <= ESPERA;
                        lider_o <= ~lider_o;
                        cnt     <= '0;
                        bomba_o <= 2'b00;
                    end else if (cnt == C_MAX) begin
                        state    <= FALLA;
                        falla_o  <= 2'b10;
                        alarma_o <= 1'b1;
                        bomba_o  <= 2'b00;
                    end else begin
                        if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                        // Run counter keeps going so the timeout covers the whole fill.
                        if (state == LLENANDO && cnt == C_ASIST && lvl == 3'b000) begin
                            state   <= ASISTENCIA;
                            bomba_o <= 2'b11;
                        end
                    end
                end
                FALLA: begin
                    if (ack_i && lvl_ok) begin
                        state    <= ESPERA;
                        falla_o  <= 2'b00;
                        alarma_o <= 1'b0;
                        cnt      <= '0;
                    end
                end
                default: begin
                    state    <= ESPERA;
                    cnt      <= '0;
                    bomba_o  <= 2'b00;
                    alarma_o <= 1'b0;
                    falla_o  <= 2'b00;
                end
            endcase
        end
    end

endmodule
